inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_fifo.sv | 53 +++++
 rtl/inst_fetch.sv | 159 +++++++++++++++
 tb/tb_inst_fetch.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, reset vector, FSM encoding and entry packing for inst_fetch
package inst_fetch_pkg;

    localparam int          WORD_W       = 16;
    localparam int          ENTRY_W      = 2 * WORD_W;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Queue entry layout: word in the upper half, fetch address in the lower half.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [WORD_W-1:0] word,
                                                      input logic [WORD_W-1:0] addr);
        return {word, addr};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - fetch_fifo: prefetch queue of {word, addr} entries
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push/i_data write one entry at the tail
//   i_pop         drop the head entry
//   i_flush       empty the queue (wins over push/pop)
//   o_head        entry at the head (meaningless when o_count == 0)
//   o_count       number of entries held
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [ENTRY_W-1:0] o_head,
    output logic [CW-1:0]      o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction prefetch unit: fetch FSM, fetch PC and prefetch queue
//
// Optional feature: INST_FETCH_BYPASS_EN (0-cycle delivery of the returning word
// when the queue is empty).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   o_mem_addr/o_mem_req          memory read request, held until i_mem_ack
//   i_mem_ack/i_mem_data          memory response, data valid with ack
//   o_word/o_word_pc/o_word_valid head word and its fetch address to the decoder
//   i_word_ready                  decoder consumes the head word
//   i_jump/i_jump_addr            redirect: flush queue, restart at target
//   i_lock                        freeze new requests and delivery
//   o_empty                       queue holds zero entries
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    output logic [15:0] o_word,
    output logic        o_word_valid,
    input  logic        i_word_ready,
    output logic [15:0] o_word_pc,
    input  logic        i_jump,
    input  logic [15:0] i_jump_addr,
    input  logic        i_lock,
    output logic        o_empty
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t       r_state;
    logic [15:0]        r_fetch_pc;
    logic [15:0]        r_mem_addr;
    logic               r_mem_req;

    logic [CW-1:0]      w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_empty;
    logic               w_ack_wait;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [CW:0]        w_count_after;
    logic               w_can_issue;
    logic [15:0]        w_pc_inc;

    assign w_empty    = (w_count == '0);
    assign w_ack_wait = (r_state == WAIT) && i_mem_ack;

`ifdef INST_FETCH_BYPASS_EN
    // The returning word is shown straight to the decoder while the queue is empty.
    assign w_bypass = w_empty && !i_lock && (r_state == WAIT);
`else
    assign w_bypass = 1'b0;
`endif

    // A jump flushes the queue, so a same-cycle pop and any returning data are dropped.
    assign w_pop  = !w_empty && !i_lock && i_word_ready && !i_jump;
    assign w_push = w_ack_wait && !i_jump && !(w_bypass && i_word_ready);

    // Occupancy after this cycle's push/pop; a new request reserves one more slot,
    // which is what keeps the queue from ever overflowing.
    assign w_count_after = (CW+1)'(w_count) + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_can_issue   = !i_lock && !i_jump && (w_count_after < (CW+1)'(DEPTH));
    assign w_pc_inc      = r_fetch_pc + 16'd1;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (pack_entry(i_mem_data, r_mem_addr)),
        .i_pop   (w_pop),
        .i_flush (i_jump),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_req  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_jump) begin
                        r_fetch_pc <= i_jump_addr;
                        r_mem_addr <= i_jump_addr;
                    end else if (w_can_issue) begin
                        r_state    <= WAIT;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                WAIT: begin
                    if (i_jump) begin
                        r_fetch_pc <= i_jump_addr;
                        if (i_mem_ack) begin
                            r_state    <= IDLE;
                            r_mem_req  <= 1'b0;
                            r_mem_addr <= i_jump_addr;
                        end else begin
                            // Request stays on the bus; its data will be thrown away.
                            r_state <= DROP;
                        end
                    end else if (i_mem_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        r_mem_addr <= w_pc_inc;
                        if (!w_can_issue) begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (i_jump) r_fetch_pc <= i_jump_addr;
                    if (i_mem_ack) begin
                        r_state    <= IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= i_jump ? i_jump_addr : r_fetch_pc;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_empty    = w_empty;

    always_comb begin
        o_word_valid = !w_empty && !i_lock;
        o_word       = w_empty ? 16'h0000 : w_head[ENTRY_W-1:WORD_W];
        o_word_pc    = w_empty ? 16'h0000 : w_head[WORD_W-1:0];
`ifdef INST_FETCH_BYPASS_EN
        if (w_bypass) begin
            o_word_valid = i_mem_ack;
            o_word       = i_mem_data;
            o_word_pc    = r_mem_addr;
        end
`endif
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized self-checking bench for inst_fetch against a queue-level model
module tb_inst_fetch;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] o_mem_addr;
    logic        o_mem_req;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    logic [15:0] o_word;
    logic        o_word_valid;
    logic        i_word_ready;
    logic [15:0] o_word_pc;
    logic        i_jump;
    logic [15:0] i_jump_addr;
    logic        i_lock;
    logic        o_empty;

    always #5 clk = ~clk;

    inst_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .o_mem_addr   (o_mem_addr),
        .o_mem_req    (o_mem_req),
        .i_mem_ack    (i_mem_ack),
        .i_mem_data   (i_mem_data),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_word_pc    (o_word_pc),
        .i_jump       (i_jump),
        .i_jump_addr  (i_jump_addr),
        .i_lock       (i_lock),
        .o_empty      (o_empty)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the prefetch stream as a queue of {word, pc}, plus the one
    // memory request in flight (0 none, 1 live, 2 cancelled by a jump).
    logic [31:0] q[$];
    int          os;
    logic [15:0] os_addr;
    logic [15:0] next_pc;
    int          n_delivered;

    task automatic model_step();
        int  prev_os;
        bit  live_ack;
        bit  take;
        bit  byp_take;
        prev_os  = os;
        live_ack = i_mem_ack && (os == 1) && !i_jump;
        take     = !i_jump && (q.size() > 0) && !i_lock && i_word_ready;
        byp_take = 1'b0;
`ifdef INST_FETCH_BYPASS_EN
        byp_take = live_ack && (q.size() == 0) && !i_lock && i_word_ready;
`endif
        if (rst) begin
            q.delete();
            os      = 0;
            next_pc = RPC;
            return;
        end
        if (take) begin
            void'(q.pop_front());
            n_delivered++;
        end
        if (byp_take) n_delivered++;
        if (live_ack && !byp_take) q.push_back({i_mem_data, os_addr});
        if (i_mem_ack && os != 0) begin
            if (live_ack) next_pc = os_addr + 16'd1;
            os = 0;
        end
        if (i_jump) begin
            q.delete();
            next_pc = i_jump_addr;
            if (os == 1) os = 2;
        end
        if (!i_lock && !i_jump && q.size() < DEPTH && os == 0 &&
            (prev_os == 0 || (prev_os == 1 && i_mem_ack))) begin
            os      = 1;
            os_addr = next_pc;
        end
    endtask

    task automatic check_outputs(input bit after_reset);
        bit          exp_valid;
        logic [31:0] exp_entry;
        exp_valid = (q.size() > 0) && !i_lock;
        exp_entry = (q.size() > 0) ? q[0] : 32'h0;
`ifdef INST_FETCH_BYPASS_EN
        if (q.size() == 0 && !i_lock && os == 1) begin
            exp_valid = i_mem_ack;
            exp_entry = {i_mem_data, os_addr};
        end
`endif
        check("mem_req", {31'h0, o_mem_req}, {31'h0, os != 0});
        if (os != 0) check("mem_addr", {16'h0, o_mem_addr}, {16'h0, os_addr});
        check("empty", {31'h0, o_empty}, {31'h0, q.size() == 0});
        check("word_valid", {31'h0, o_word_valid}, {31'h0, exp_valid});
        if (exp_valid) check("word_pc", {o_word, o_word_pc}, exp_entry);
        if (after_reset) begin
            check("rst_word", {16'h0, o_word}, 32'h0);
            check("rst_word_pc", {16'h0, o_word_pc}, 32'h0);
            check("rst_mem_addr", {16'h0, o_mem_addr}, {16'h0, RPC});
        end
    endtask

    initial begin
        bit was_rst;
        int ready_pct;
        int r;
        rst          = 1'b1;
        i_mem_ack    = 1'b0;
        i_mem_data   = 16'h0;
        i_word_ready = 1'b0;
        i_jump       = 1'b0;
        i_jump_addr  = 16'h0;
        i_lock       = 1'b0;
        q.delete();
        os           = 0;
        os_addr      = 16'h0;
        next_pc      = RPC;
        n_delivered  = 0;

        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            was_rst = rst;
            model_step();
            #1;
            rst = (c < 2) || (c >= 3000 && c < 3002);
            // Phases alternate between a fast and a slow consumer so the queue both drains and fills.
            ready_pct    = ((c / 400) % 2 == 0) ? 90 : 20;
            i_word_ready = ($urandom_range(0, 99) < ready_pct);
            i_lock       = !rst && ($urandom_range(0, 99) < 8);
            i_jump       = !rst && ($urandom_range(0, 99) < 4);
            r            = $urandom_range(0, 3);
            i_jump_addr  = (r == 0) ? 16'h0100 : (r == 1) ? 16'hFFFE :
                           (r == 2) ? 16'hFFFF : 16'($urandom);
            i_mem_data   = 16'($urandom);
            i_mem_ack    = o_mem_req && ($urandom_range(0, 99) < 55);
            @(negedge clk);
            check_outputs(was_rst && rst);
        end

        check("delivered_some", {31'h0, n_delivered > 500}, 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
